// File: rtl/sodor5_tb_pkg.sv
// rtl/sodor5_tb_pkg.sv - shared RV opcode constants, field slices and scheduler state type
package sodor5_tb_pkg;

   localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
   localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
   localparam logic [31:0] NOP_WORD  = 32'h00000013;

   typedef enum logic {WARMUP, ARB} sched_state_t;

   function automatic logic [4:0] rd_of(input logic [31:0] w);
      return w[11:7];
   endfunction

   function automatic logic [4:0] rs1_of(input logic [31:0] w);
      return w[19:15];
   endfunction

   function automatic logic [6:0] opcode_of(input logic [31:0] w);
      return w[6:0];
   endfunction

endpackage

// File: rtl/wrr_arbiter2.sv
// rtl/wrr_arbiter2.sv - two-way weighted round-robin grant with per-source credit
module wrr_arbiter2 #(
   parameter logic [3:0] W_A = 4'd1,
   parameter logic [3:0] W_B = 4'd1
) (
   input  logic clk,
   input  logic reset,
   input  logic req_a,
   input  logic req_b,
   input  logic advance,
   output logic gnt_a,
   output logic gnt_b
);

   logic       ptr_b;
   logic       ptr_b_nxt;
   logic [3:0] credit;
   logic [3:0] credit_nxt;
   logic       en_a;
   logic       en_b;
   logic       cur_req;
   logic       oth_req;
   logic       gnt;
   logic       gnt_sel_b;

   // A zero weight removes that source from arbitration entirely.
   always_comb begin
      en_a       = req_a && (W_A != 4'd0);
      en_b       = req_b && (W_B != 4'd0);
      cur_req    = ptr_b ? en_b : en_a;
      oth_req    = ptr_b ? en_a : en_b;
      gnt        = 1'b0;
      gnt_sel_b  = ptr_b;
      ptr_b_nxt  = ptr_b;
      credit_nxt = credit;
      if (cur_req && (credit != 4'd0)) begin
         gnt        = 1'b1;
         credit_nxt = credit - 4'd1;
      end else if (oth_req) begin
         gnt        = 1'b1;
         gnt_sel_b  = ~ptr_b;
         ptr_b_nxt  = ~ptr_b;
         credit_nxt = (ptr_b ? W_A : W_B) - 4'd1;
      end else if (cur_req) begin
         gnt        = 1'b1;
         credit_nxt = (ptr_b ? W_B : W_A) - 4'd1;
      end
      gnt_a = gnt && !gnt_sel_b;
      gnt_b = gnt && gnt_sel_b;
   end

   // State only moves when the granted candidate is actually consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_b  <= 1'b0;
         credit <= W_A;
      end else if (advance && gnt) begin
         ptr_b  <= ptr_b_nxt;
         credit <= credit_nxt;
      end
   end

endmodule

// File: rtl/imem_instr_scheduler.sv
// rtl/imem_instr_scheduler.sv - imem word sequencer: warm-up NOPs, WRR of ALU/load sources, load-use bubbles
module imem_instr_scheduler #(
   parameter logic [31:0] NOP_WORD   = sodor5_tb_pkg::NOP_WORD,
   parameter int          RESET_NOPS = 3,
   parameter logic [3:0]  W_ALU      = 4'd1,
   parameter logic [3:0]  W_LD       = 4'd1,
   parameter int          LU_BUBBLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [31:0] alu_instr,
   output logic        alu_ready,
   input  logic        ld_valid,
   input  logic [31:0] ld_instr,
   output logic        ld_ready,
   input  logic        imem_ready,
   output logic        imem_valid,
   output logic [31:0] imem_data,
   output logic [31:0] issue_count,
   output logic [15:0] bubble_count
);

   import sodor5_tb_pkg::sched_state_t;
   import sodor5_tb_pkg::WARMUP;
   import sodor5_tb_pkg::ARB;
   import sodor5_tb_pkg::OPC_LOAD;
   import sodor5_tb_pkg::rd_of;
   import sodor5_tb_pkg::rs1_of;
   import sodor5_tb_pkg::opcode_of;

   localparam logic [3:0] WARM_INIT = 4'(RESET_NOPS);
   localparam logic [1:0] HAZ_INIT  = 2'(LU_BUBBLES);

   sched_state_t state, state_nxt;
   logic [3:0]   warm_cnt, warm_nxt;
   logic [1:0]   haz_cnt, haz_nxt;
   logic [4:0]   haz_rd, haz_rd_nxt;
   logic         valid_nxt;
   logic [31:0]  data_nxt;
   logic [31:0]  issue_nxt;
   logic [15:0]  bubble_nxt;
   logic         slot_open;
   logic         gnt_alu;
   logic         gnt_ld;
   logic         advance;
   logic         hit;
   logic [31:0]  cand;

   wrr_arbiter2 #(
      .W_A (W_ALU),
      .W_B (W_LD)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req_a   (alu_valid),
      .req_b   (ld_valid),
      .advance (advance),
      .gnt_a   (gnt_alu),
      .gnt_b   (gnt_ld)
   );

   always_comb begin
      slot_open  = !imem_valid || imem_ready;
      cand       = gnt_ld ? ld_instr : alu_instr;
      hit        = (haz_cnt != 2'd0) && (rs1_of(cand) == haz_rd);
      state_nxt  = state;
      warm_nxt   = warm_cnt;
      haz_nxt    = haz_cnt;
      haz_rd_nxt = haz_rd;
      valid_nxt  = imem_valid;
      data_nxt   = imem_data;
      bubble_nxt = bubble_count;
      issue_nxt  = issue_count + {31'd0, imem_valid && imem_ready};
      advance    = 1'b0;
      alu_ready  = 1'b0;
      ld_ready   = 1'b0;
      case (state)
         WARMUP: begin
            if (warm_cnt == 4'd0) begin
               state_nxt = ARB;
               if (slot_open) begin
                  valid_nxt = 1'b0;
                  data_nxt  = NOP_WORD;
               end
            end else if (slot_open) begin
               valid_nxt = 1'b1;
               data_nxt  = NOP_WORD;
               warm_nxt  = warm_cnt - 4'd1;
               if (warm_cnt == 4'd1) state_nxt = ARB;
            end
         end
         ARB: begin
            if (slot_open) begin
               if (!(gnt_alu || gnt_ld)) begin
                  valid_nxt = 1'b0;
                  data_nxt  = NOP_WORD;
               end else if (hit) begin
                  // Bubble: candidate stays at its source for the next slot.
                  valid_nxt  = 1'b1;
                  data_nxt   = NOP_WORD;
                  haz_nxt    = haz_cnt - 2'd1;
                  bubble_nxt = (bubble_count == 16'hFFFF) ? bubble_count : bubble_count + 16'd1;
               end else begin
                  valid_nxt = 1'b1;
                  data_nxt  = cand;
                  advance   = 1'b1;
                  alu_ready = gnt_alu;
                  ld_ready  = gnt_ld;
                  if (haz_cnt != 2'd0) haz_nxt = haz_cnt - 2'd1;
                  if ((opcode_of(cand) == OPC_LOAD) && (rd_of(cand) != 5'd0)) begin
                     haz_rd_nxt = rd_of(cand);
                     haz_nxt    = HAZ_INIT;
                  end
               end
            end
         end
      endcase
      if (reset) begin
         advance   = 1'b0;
         alu_ready = 1'b0;
         ld_ready  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= WARMUP;
         warm_cnt     <= WARM_INIT;
         haz_cnt      <= 2'd0;
         haz_rd       <= 5'd0;
         imem_valid   <= 1'b0;
         imem_data    <= NOP_WORD;
         issue_count  <= 32'd0;
         bubble_count <= 16'd0;
      end else begin
         state        <= state_nxt;
         warm_cnt     <= warm_nxt;
         haz_cnt      <= haz_nxt;
         haz_rd       <= haz_rd_nxt;
         imem_valid   <= valid_nxt;
         imem_data    <= data_nxt;
         issue_count  <= issue_nxt;
         bubble_count <= bubble_nxt;
      end
   end

endmodule
